// File: rtl/alu_response_checker.sv
// ============================================================================
// alu_response_checker
// ----------------------------------------------------------------------------
// In-order response checker for the ALU verification environment.
// Expected responses are queued together with a feature ID. Each DUT response
// pops the queue head and is compared against it. The result of that compare
// lands one cycle later in saturating pass/fail counters. Failing transactions
// are logged in a drainable FIFO.
//
// Response packing (RSP_W = 2*DATA_WIDTH+7 bits), MSB to LSB:
//     {RES[2W:0], COUT, G, L, E, OFLOW, ERR}
//
// Optional feature macro:
//     CHK_MASK_EN  - adds the exp_mask port. A per-entry don't-care mask is
//                    stored with each entry, and masked bits never mismatch.
//
// Ports:
//     clk, rst               clock (rising edge), asynchronous active-high reset
//     clr                    synchronous clear of all state
//     exp_valid/exp_ready    expected-entry handshake
//     exp_id, exp_data       expected entry fields
//     exp_mask               don't-care bits (CHK_MASK_EN only)
//     act_valid, act_data    DUT response (no back-pressure)
//     pass_cnt, fail_cnt     saturating compare counters
//     orphan                 sticky: response arrived with the queue empty
//     fail_ovf               sticky: a fail record was dropped (log full)
//     pending                expected-queue occupancy
//     fail_valid/fail_ready  fail-log head handshake
//     fail_id/exp/act        fail-log head fields (zero while log empty)
// ============================================================================
module alu_response_checker #(
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = 8,
    parameter int EXP_DEPTH  = 8,
    parameter int FAIL_DEPTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       exp_valid,
    output logic                       exp_ready,
    input  logic [ID_WIDTH-1:0]        exp_id,
    input  logic [2*DATA_WIDTH+6:0]    exp_data,
`ifdef CHK_MASK_EN
    input  logic [2*DATA_WIDTH+6:0]    exp_mask,
`endif
    input  logic                       act_valid,
    input  logic [2*DATA_WIDTH+6:0]    act_data,
    output logic [CNT_WIDTH-1:0]       pass_cnt,
    output logic [CNT_WIDTH-1:0]       fail_cnt,
    output logic                       orphan,
    output logic                       fail_ovf,
    output logic [$clog2(EXP_DEPTH):0] pending,
    output logic                       fail_valid,
    input  logic                       fail_ready,
    output logic [ID_WIDTH-1:0]        fail_id,
    output logic [2*DATA_WIDTH+6:0]    fail_exp,
    output logic [2*DATA_WIDTH+6:0]    fail_act
);

    localparam int RSP_W = 2*DATA_WIDTH + 7;
    localparam int EAW   = $clog2(EXP_DEPTH);
    localparam int FAW   = $clog2(FAIL_DEPTH);
    localparam int EPW   = EAW + 1;
    localparam int FPW   = FAW + 1;
    localparam logic [EPW-1:0] EXP_FULL  = EPW'(EXP_DEPTH);
    localparam logic [FPW-1:0] FAIL_FULL = FPW'(FAIL_DEPTH);

    // ------------------------------------------------------------------
    // Expected queue
    // ------------------------------------------------------------------
    logic [ID_WIDTH-1:0] exp_id_mem   [EXP_DEPTH];
    logic [RSP_W-1:0]    exp_data_mem [EXP_DEPTH];
`ifdef CHK_MASK_EN
    logic [RSP_W-1:0]    exp_mask_mem [EXP_DEPTH];
`endif
    logic [EPW-1:0]      exp_wr_ptr;
    logic [EPW-1:0]      exp_rd_ptr;
    logic                exp_push;
    logic                exp_pop;
    logic                head_match;

    // Pointers carry one extra bit, so full (difference == depth) and empty
    // (difference == 0) stay distinguishable after wrapping.
    assign pending   = exp_wr_ptr - exp_rd_ptr;
    // Ready depends only on occupancy. A same-cycle pop does not open a slot.
    assign exp_ready = (pending != EXP_FULL);
    assign exp_push  = exp_valid && exp_ready && !clr;
    // There is no bypass. A response against an empty queue is an orphan,
    // even if a push lands in the same cycle.
    assign exp_pop   = act_valid && (pending != '0) && !clr;

`ifdef CHK_MASK_EN
    assign head_match = ((exp_data_mem[exp_rd_ptr[EAW-1:0]] ^ act_data)
                         & ~exp_mask_mem[exp_rd_ptr[EAW-1:0]]) == '0;
`else
    assign head_match = (exp_data_mem[exp_rd_ptr[EAW-1:0]] == act_data);
`endif

    always_ff @(posedge clk) begin
        if (exp_push) begin
            exp_id_mem[exp_wr_ptr[EAW-1:0]]   <= exp_id;
            exp_data_mem[exp_wr_ptr[EAW-1:0]] <= exp_data;
`ifdef CHK_MASK_EN
            exp_mask_mem[exp_wr_ptr[EAW-1:0]] <= exp_mask;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_wr_ptr <= '0;
            exp_rd_ptr <= '0;
            orphan     <= 1'b0;
        end else if (clr) begin
            exp_wr_ptr <= '0;
            exp_rd_ptr <= '0;
            orphan     <= 1'b0;
        end else begin
            if (exp_push) exp_wr_ptr <= exp_wr_ptr + 1'b1;
            if (exp_pop)  exp_rd_ptr <= exp_rd_ptr + 1'b1;
            if (act_valid && (pending == '0)) orphan <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Compare stage: holds one popped transaction and its match result
    // ------------------------------------------------------------------
    logic                cmp_valid;
    logic                cmp_match;
    logic [ID_WIDTH-1:0] cmp_id;
    logic [RSP_W-1:0]    cmp_exp;
    logic [RSP_W-1:0]    cmp_act;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_valid <= 1'b0;
            cmp_match <= 1'b0;
            cmp_id    <= '0;
            cmp_exp   <= '0;
            cmp_act   <= '0;
        end else if (clr) begin
            // Clearing here drops any in-flight compare, so it is never counted.
            cmp_valid <= 1'b0;
            cmp_match <= 1'b0;
            cmp_id    <= '0;
            cmp_exp   <= '0;
            cmp_act   <= '0;
        end else begin
            cmp_valid <= exp_pop;
            if (exp_pop) begin
                cmp_match <= head_match;
                cmp_id    <= exp_id_mem[exp_rd_ptr[EAW-1:0]];
                cmp_exp   <= exp_data_mem[exp_rd_ptr[EAW-1:0]];
                cmp_act   <= act_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result stage: counters and fail log
    // ------------------------------------------------------------------
    logic [ID_WIDTH-1:0] fail_id_mem  [FAIL_DEPTH];
    logic [RSP_W-1:0]    fail_exp_mem [FAIL_DEPTH];
    logic [RSP_W-1:0]    fail_act_mem [FAIL_DEPTH];
    logic [FPW-1:0]      fail_wr_ptr;
    logic [FPW-1:0]      fail_rd_ptr;
    logic [FPW-1:0]      fail_count;
    logic                fail_req;
    logic                fail_pop;
    logic                fail_push;

    assign fail_count = fail_wr_ptr - fail_rd_ptr;
    assign fail_valid = (fail_count != '0);
    assign fail_pop   = fail_ready && fail_valid && !clr;
    assign fail_req   = cmp_valid && !cmp_match;
    // A pop in the same cycle frees the slot the new record needs.
    assign fail_push  = fail_req && ((fail_count != FAIL_FULL) || fail_pop) && !clr;

    // The head fields read as zero while the log is empty, which keeps them
    // at their reset value without clearing the storage array.
    assign fail_id  = fail_valid ? fail_id_mem[fail_rd_ptr[FAW-1:0]]  : '0;
    assign fail_exp = fail_valid ? fail_exp_mem[fail_rd_ptr[FAW-1:0]] : '0;
    assign fail_act = fail_valid ? fail_act_mem[fail_rd_ptr[FAW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (fail_push) begin
            fail_id_mem[fail_wr_ptr[FAW-1:0]]  <= cmp_id;
            fail_exp_mem[fail_wr_ptr[FAW-1:0]] <= cmp_exp;
            fail_act_mem[fail_wr_ptr[FAW-1:0]] <= cmp_act;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_wr_ptr <= '0;
            fail_rd_ptr <= '0;
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            fail_ovf    <= 1'b0;
        end else if (clr) begin
            fail_wr_ptr <= '0;
            fail_rd_ptr <= '0;
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            fail_ovf    <= 1'b0;
        end else begin
            if (fail_push) fail_wr_ptr <= fail_wr_ptr + 1'b1;
            if (fail_pop)  fail_rd_ptr <= fail_rd_ptr + 1'b1;
            if (cmp_valid && cmp_match && (pass_cnt != '1))
                pass_cnt <= pass_cnt + 1'b1;
            // A failure is counted even when its log record has to be dropped.
            if (fail_req && (fail_cnt != '1))
                fail_cnt <= fail_cnt + 1'b1;
            if (fail_req && !fail_push)
                fail_ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_response_checker.sv
// ============================================================================
// tb_alu_response_checker
// ----------------------------------------------------------------------------
// Directed testbench for alu_response_checker with hand-computed expected
// values. Inputs change 1 ns after each rising edge, and outputs are checked
// there as well.
// ============================================================================
module tb_alu_response_checker;

    localparam int DW = 8;
    localparam int IW = 8;
    localparam int RW = 2*DW + 7;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic          exp_valid;
    logic          exp_ready;
    logic [IW-1:0] exp_id;
    logic [RW-1:0] exp_data;
`ifdef CHK_MASK_EN
    logic [RW-1:0] exp_mask;
`endif
    logic          act_valid;
    logic [RW-1:0] act_data;
    logic [CW-1:0] pass_cnt;
    logic [CW-1:0] fail_cnt;
    logic          orphan;
    logic          fail_ovf;
    logic [3:0]    pending;
    logic          fail_valid;
    logic          fail_ready;
    logic [IW-1:0] fail_id;
    logic [RW-1:0] fail_exp;
    logic [RW-1:0] fail_act;

    int total = 0;
    int bad   = 0;

    alu_response_checker #(
        .DATA_WIDTH(DW), .ID_WIDTH(IW), .EXP_DEPTH(8), .FAIL_DEPTH(16), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_id(exp_id), .exp_data(exp_data),
`ifdef CHK_MASK_EN
        .exp_mask(exp_mask),
`endif
        .act_valid(act_valid), .act_data(act_data),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .orphan(orphan), .fail_ovf(fail_ovf),
        .pending(pending), .fail_valid(fail_valid), .fail_ready(fail_ready),
        .fail_id(fail_id), .fail_exp(fail_exp), .fail_act(fail_act)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of expected-side and actual-side inputs.
    task automatic applyStimulus(input logic ev, input logic [IW-1:0] id, input logic [RW-1:0] ed,
                                 input logic av, input logic [RW-1:0] ad);
        exp_valid = ev;
        exp_id    = id;
        exp_data  = ed;
        act_valid = av;
        act_data  = ad;
        tick();
        exp_valid = 1'b0;
        act_valid = 1'b0;
    endtask

    task automatic checkIdle(input string pfx);
        checkOutput({pfx, "_exp_ready"},  32'(exp_ready),  32'd1);
        checkOutput({pfx, "_pending"},    32'(pending),    32'd0);
        checkOutput({pfx, "_pass_cnt"},   32'(pass_cnt),   32'd0);
        checkOutput({pfx, "_fail_cnt"},   32'(fail_cnt),   32'd0);
        checkOutput({pfx, "_orphan"},     32'(orphan),     32'd0);
        checkOutput({pfx, "_fail_ovf"},   32'(fail_ovf),   32'd0);
        checkOutput({pfx, "_fail_valid"}, 32'(fail_valid), 32'd0);
        checkOutput({pfx, "_fail_id"},    32'(fail_id),    32'd0);
        checkOutput({pfx, "_fail_exp"},   32'(fail_exp),   32'd0);
        checkOutput({pfx, "_fail_act"},   32'(fail_act),   32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        clr        = 1'b0;
        exp_valid  = 1'b0;
        exp_id     = '0;
        exp_data   = '0;
`ifdef CHK_MASK_EN
        exp_mask   = '0;
`endif
        act_valid  = 1'b0;
        act_data   = '0;
        fail_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checkIdle("reset");

        // Basic pass: result lands two edges after act_valid is driven.
        applyStimulus(1'b1, 8'h01, 23'h000180, 1'b0, '0);
        checkOutput("basic_pending_push", 32'(pending), 32'd1);
        applyStimulus(1'b0, '0, '0, 1'b1, 23'h000180);
        checkOutput("basic_pending_pop", 32'(pending), 32'd0);
        checkOutput("basic_pass_early", 32'(pass_cnt), 32'd0);
        tick();
        checkOutput("basic_pass", 32'(pass_cnt), 32'd1);
        checkOutput("basic_fail", 32'(fail_cnt), 32'd0);
        checkOutput("basic_fvalid", 32'(fail_valid), 32'd0);

        // Single mismatch, then pop it from the log.
        applyStimulus(1'b1, 8'h07, 23'h000100, 1'b0, '0);
        applyStimulus(1'b0, '0, '0, 1'b1, 23'h000101);
        tick();
        checkOutput("mis_fail_cnt", 32'(fail_cnt), 32'd1);
        checkOutput("mis_pass_cnt", 32'(pass_cnt), 32'd1);
        checkOutput("mis_fvalid", 32'(fail_valid), 32'd1);
        checkOutput("mis_fid", 32'(fail_id), 32'h07);
        checkOutput("mis_fexp", 32'(fail_exp), 32'h000100);
        checkOutput("mis_fact", 32'(fail_act), 32'h000101);
        fail_ready = 1'b1;
        tick();
        fail_ready = 1'b0;
        checkOutput("mis_pop_fvalid", 32'(fail_valid), 32'd0);

        // Fill the queue; the push offered while full is ignored, including
        // the cycle where a pop happens at the same time.
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b1, 8'(i), 23'(i*3+1), 1'b0, '0);
        checkOutput("full_ready", 32'(exp_ready), 32'd0);
        checkOutput("full_pending", 32'(pending), 32'd8);
        applyStimulus(1'b1, 8'h99, 23'h7FFFFF, 1'b0, '0);
        checkOutput("full_ninth", 32'(pending), 32'd8);
        applyStimulus(1'b1, 8'h99, 23'h7FFFFF, 1'b1, 23'h000001);
        checkOutput("full_pushpop", 32'(pending), 32'd7);
        for (int i = 1; i < 8; i++)
            applyStimulus(1'b0, '0, '0, 1'b1, 23'(i*3+1));
        tick();
        checkOutput("order_pass", 32'(pass_cnt), 32'd9);
        checkOutput("order_fail", 32'(fail_cnt), 32'd1);
        checkOutput("order_pending", 32'(pending), 32'd0);
        checkOutput("order_ready", 32'(exp_ready), 32'd1);

        // Orphan: act against an empty queue while an entry is pushed.
        applyStimulus(1'b1, 8'h33, 23'h000055, 1'b1, 23'h000055);
        checkOutput("orph_flag", 32'(orphan), 32'd1);
        checkOutput("orph_pending", 32'(pending), 32'd1);
        tick();
        checkOutput("orph_pass", 32'(pass_cnt), 32'd9);
        checkOutput("orph_fail", 32'(fail_cnt), 32'd1);
        applyStimulus(1'b0, '0, '0, 1'b1, 23'h000055);
        tick();
        checkOutput("orph_drain_pass", 32'(pass_cnt), 32'd10);
        checkOutput("orph_sticky", 32'(orphan), 32'd1);

        // Clear wins over a simultaneous push and orphan act.
        clr = 1'b1;
        applyStimulus(1'b1, 8'h44, 23'h000044, 1'b1, 23'h000044);
        clr = 1'b0;
        checkIdle("clr");

        // Fail-log overflow: 17 mismatches with no pops.
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, 8'(i), 23'(i+5), 1'b0, '0);
            applyStimulus(1'b0, '0, '0, 1'b1, 23'((i+5) ^ 2));
        end
        checkOutput("ovf_cnt16", 32'(fail_cnt), 32'd16);
        checkOutput("ovf_not_yet", 32'(fail_ovf), 32'd0);
        tick();
        checkOutput("ovf_cnt17", 32'(fail_cnt), 32'd17);
        checkOutput("ovf_flag", 32'(fail_ovf), 32'd1);
        checkOutput("ovf_head", 32'(fail_id), 32'd0);

        // A record landing on a full log alongside a pop is accepted.
        applyStimulus(1'b1, 8'd17, 23'd22, 1'b0, '0);
        applyStimulus(1'b0, '0, '0, 1'b1, 23'(22 ^ 2));
        fail_ready = 1'b1;
        tick();
        fail_ready = 1'b0;
        checkOutput("ovf_cnt18", 32'(fail_cnt), 32'd18);
        for (int k = 0; k < 16; k++) begin
            int id;
            id = (k < 15) ? k + 1 : 17;
            checkOutput($sformatf("log%0d_valid", k), 32'(fail_valid), 32'd1);
            checkOutput($sformatf("log%0d_id", k), 32'(fail_id), 32'(id));
            checkOutput($sformatf("log%0d_exp", k), 32'(fail_exp), 32'(id+5));
            checkOutput($sformatf("log%0d_act", k), 32'(fail_act), 32'((id+5) ^ 2));
            fail_ready = 1'b1;
            tick();
            fail_ready = 1'b0;
        end
        checkOutput("log_empty", 32'(fail_valid), 32'd0);

        // Clear with a mismatch in flight: it must never be counted.
        applyStimulus(1'b1, 8'h21, 23'h000010, 1'b0, '0);
        applyStimulus(1'b0, '0, '0, 1'b1, 23'h000011);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checkIdle("clr_flight");
        tick();
        checkOutput("clr_flight_fail", 32'(fail_cnt), 32'd0);
        checkOutput("clr_flight_fvalid", 32'(fail_valid), 32'd0);

        // Asynchronous reset in mid-cycle with a compare in flight.
        applyStimulus(1'b1, 8'h22, 23'h000020, 1'b0, '0);
        applyStimulus(1'b1, 8'h23, 23'h000030, 1'b0, '0);
        applyStimulus(1'b0, '0, '0, 1'b1, 23'h000020);
        #2;
        rst = 1'b1;
        #1;
        checkIdle("arst");
        #1;
        rst = 1'b0;
        tick();
        checkOutput("arst_pass", 32'(pass_cnt), 32'd0);
        checkOutput("arst_pending", 32'(pending), 32'd0);

`ifdef CHK_MASK_EN
        // A masked ERR bit does not cause a mismatch.
        exp_mask = 23'h000001;
        applyStimulus(1'b1, 8'h05, 23'h000180, 1'b0, '0);
        exp_mask = '0;
        applyStimulus(1'b0, '0, '0, 1'b1, 23'h000181);
        tick();
        checkOutput("mask_pass", 32'(pass_cnt), 32'd1);
        checkOutput("mask_fail", 32'(fail_cnt), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
